// File: rtl/iram_burst.sv
// Instruction RAM with a program-load write port and a handshaked burst read port.
// Reads stream consecutive words from a captured start address, wrapping at DEPTH.
module iram_burst #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy
);
    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr, ptr_d, nxt, raddr;
    logic [LEN_W-1:0]  cnt, cnt_d;
    logic [DATA_W-1:0] rword, data_d;
    logic              valid_d, last_d;

    // Memory has no reset so loaded programs survive a core reset.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_X))
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end

    // Addresses past DEPTH read as zero; the index slice is only used when in range.
    assign nxt   = (ptr == LAST_A) ? '0 : ptr + 1'b1;
    assign raddr = (state == IDLE) ? rd_addr : nxt;
    assign rword = ({1'b0, raddr} < DEPTH_X) ? mem[raddr[IDX_W-1:0]] : '0;
    assign busy  = (state == BURST);

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        data_d  = rd_data;
        valid_d = rd_valid;
        last_d  = rd_last;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    state_d = BURST;
                    ptr_d   = rd_addr;
                    cnt_d   = rd_len;
                    data_d  = rword;
                    valid_d = 1'b1;
                    last_d  = (rd_len == '0);
                end
            end
            BURST: begin
                if (rd_valid && rd_ready) begin
                    if (rd_last) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        ptr_d  = nxt;
                        cnt_d  = cnt - 1'b1;
                        data_d = rword;
                        last_d = (cnt == LEN_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output slot is registered, so a write to the held address cannot disturb rd_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            cnt      <= cnt_d;
            rd_data  <= data_d;
            rd_valid <= valid_d;
            rd_last  <= last_d;
        end
    end
endmodule
